// File: rtl/mc_ctrl_if.sv
// Shared memory port between the mc_ctrl sequencer (master) and the
// instruction/data memory (slave): request, write qualifier, address select, ack.
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output iord, input mem_ack);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer with a shared memory port handshake.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | request instruction word; IR/PC written on mem_ack
// S_DECODE | classify opcode/funct; nop retires here, illegal -> S_HALT
// S_EXEC   | ALU / branch / jump controls
// S_MEM    | data access for lw/lb/sw, held until mem_ack
// S_WB     | register file write-back
// S_HALT   | illegal instruction seen; only reset leaves
module mc_ctrl (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    mc_ctrl_if.master         mem,
    output logic              ir_we,
    output logic              pc_we,
    output logic              reg_we,
    output logic [2:0]        alu_op,
    output logic              alu_src,
    output logic [1:0]        ext_op,
    output logic [1:0]        reg_dst,
    output logic [2:0]        mem2reg,
    output logic [2:0]        npc_sel,
    output logic              halted,
    output logic [31:0]       instr_retired,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_LB, I_SW,
        I_BEQ, I_J, I_JAL, I_JR, I_ILL
    } instr_t;

    state_t state, state_nx;
    instr_t instr;
    logic   req, we, iord_c;

    always_comb begin
        instr = I_ILL;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: instr = I_ADDU;
                    6'b100011: instr = I_SUBU;
                    6'b001000: instr = I_JR;
                    6'b000000: instr = I_NOP;
                    default:   instr = I_ILL;
                endcase
            end
            6'b001101: instr = I_ORI;
            6'b001111: instr = I_LUI;
            6'b100011: instr = I_LW;
            6'b100000: instr = I_LB;
            6'b101011: instr = I_SW;
            6'b000100: instr = I_BEQ;
            6'b000010: instr = I_J;
            6'b000011: instr = I_JAL;
            default:   instr = I_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        we       = 1'b0;
        iord_c   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        alu_op   = 3'd0;
        alu_src  = 1'b0;
        ext_op   = 2'd0;
        reg_dst  = 2'd0;
        mem2reg  = 3'd0;
        npc_sel  = 3'd0;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (mem.mem_ack) begin
                    ir_we    = 1'b1;
                    pc_we    = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                case (instr)
                    I_NOP:   state_nx = S_FETCH;
                    I_ILL:   state_nx = S_HALT;
                    default: state_nx = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                case (instr)
                    I_ADDU: state_nx = S_WB;
                    I_SUBU: begin alu_op = 3'd1; state_nx = S_WB; end
                    I_ORI: begin
                        alu_op = 3'd2; alu_src = 1'b1; state_nx = S_WB;
                    end
                    I_LUI: begin
                        alu_src = 1'b1; ext_op = 2'd2; state_nx = S_WB;
                    end
                    I_LW, I_LB, I_SW: begin
                        alu_src = 1'b1; ext_op = 2'd1; state_nx = S_MEM;
                    end
                    I_BEQ: begin
                        alu_op = 3'd1; ext_op = 2'd1; npc_sel = 3'd1; pc_we = zero;
                    end
                    I_J:   begin pc_we = 1'b1; npc_sel = 3'd2; end
                    I_JAL: begin
                        pc_we = 1'b1; npc_sel = 3'd2;
                        reg_we = 1'b1; reg_dst = 2'd2; mem2reg = 3'd3;
                    end
                    I_JR:  begin pc_we = 1'b1; npc_sel = 3'd3; end
                    default: state_nx = S_FETCH;
                endcase
            end
            S_MEM: begin
                // address computation stays on the ALU while the access is pending
                req     = 1'b1;
                iord_c  = 1'b1;
                we      = (instr == I_SW);
                alu_src = 1'b1;
                ext_op  = 2'd1;
                if (mem.mem_ack) state_nx = (instr == I_SW) ? S_FETCH : S_WB;
            end
            S_WB: begin
                reg_we   = 1'b1;
                state_nx = S_FETCH;
                case (instr)
                    I_ADDU, I_SUBU: reg_dst = 2'd1;
                    I_LUI:  begin ext_op = 2'd2; mem2reg = 3'd2; end
                    I_LW:   mem2reg = 3'd1;
                    I_LB:   mem2reg = 3'd4;
                    default: ;
                endcase
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
        if (!reset) begin
            req     = 1'b0;
            we      = 1'b0;
            iord_c  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            alu_op  = 3'd0;
            alu_src = 1'b0;
            ext_op  = 2'd0;
            reg_dst = 2'd0;
            mem2reg = 3'd0;
            npc_sel = 3'd0;
        end
    end

    assign mem.mem_req = req;
    assign mem.mem_we  = we;
    assign mem.iord    = iord_c;
    assign halted      = (state == S_HALT);

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_q, ret_q;
    logic        retire;

    assign retire = (state_nx == S_FETCH) &&
                    (state inside {S_DECODE, S_EXEC, S_MEM, S_WB});

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (retire) ret_q <= ret_q + 32'd1;
        end
    end

    assign cycle_count   = cyc_q;
    assign instr_retired = ret_q;
`else
    assign cycle_count   = 32'd0;
    assign instr_retired = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction-level model producing the
// expected per-cycle control vector, compared every cycle on the falling edge.
module tb_mc_ctrl;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        iord;
        logic        ir_we;
        logic        pc_we;
        logic        reg_we;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic [1:0]  ext_op;
        logic [1:0]  reg_dst;
        logic [2:0]  mem2reg;
        logic [2:0]  npc_sel;
        logic        halted;
        logic        rst_low;
        logic [31:0] retired;
        logic [31:0] cycles;
    } exp_t;

    typedef enum int {
        K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_LB, K_SW,
        K_BEQ, K_J, K_JAL, K_JR, K_NOP, K_ILL
    } kind_t;

`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        ir_we, pc_we, reg_we, alu_src, halted;
    logic [2:0]  alu_op, mem2reg, npc_sel;
    logic [1:0]  ext_op, reg_dst;
    logic [31:0] instr_retired, cycle_count;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem           (bus.master),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .reg_we        (reg_we),
        .alu_op        (alu_op),
        .alu_src       (alu_src),
        .ext_op        (ext_op),
        .reg_dst       (reg_dst),
        .mem2reg       (mem2reg),
        .npc_sel       (npc_sel),
        .halted        (halted),
        .instr_retired (instr_retired),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    exp_t        expq[$];
    exp_t        hist[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ret = 32'd0;

    function automatic exp_t snap();
        exp_t s;
        s.mem_req = bus.mem_req;  s.mem_we  = bus.mem_we;  s.iord    = bus.iord;
        s.ir_we   = ir_we;        s.pc_we   = pc_we;       s.reg_we  = reg_we;
        s.alu_op  = alu_op;       s.alu_src = alu_src;     s.ext_op  = ext_op;
        s.reg_dst = reg_dst;      s.mem2reg = mem2reg;     s.npc_sel = npc_sel;
        s.halted  = halted;       s.rst_low = 1'b0;
        s.retired = instr_retired; s.cycles = cycle_count;
        return s;
    endfunction

    function automatic exp_t idle();
        exp_t e;
        e = '0;
        return e;
    endfunction

    // per-cycle compare against the model queue
    always @(negedge clk) begin
        exp_t e, g;
        cyc_no++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            g = snap();
            g.rst_low = e.rst_low;
            if (e.rst_low) g.halted = e.halted;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_vector @%0d: got %h want %h", cyc_no, g, e);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step(input exp_t e, input bit retire);
        e.retired = PERF ? m_ret : 32'd0;
        e.cycles  = PERF ? m_cyc : 32'd0;
        expq.push_back(e);
        #1;
        hist.push_back(snap());
        @(posedge clk);
        #1;
        if (!reset) begin
            m_cyc = 32'd0;
            m_ret = 32'd0;
        end else begin
            m_cyc = m_cyc + 32'd1;
            if (retire) m_ret = m_ret + 32'd1;
        end
    endtask

    task automatic encode(input kind_t k);
        funct = 6'($urandom);
        case (k)
            K_ADDU: begin opcode = 6'h00; funct = 6'h21; end
            K_SUBU: begin opcode = 6'h00; funct = 6'h23; end
            K_JR:   begin opcode = 6'h00; funct = 6'h08; end
            K_NOP:  begin opcode = 6'h00; funct = 6'h00; end
            K_ORI:  opcode = 6'h0d;
            K_LUI:  opcode = 6'h0f;
            K_LW:   opcode = 6'h23;
            K_LB:   opcode = 6'h20;
            K_SW:   opcode = 6'h2b;
            K_BEQ:  opcode = 6'h04;
            K_J:    opcode = 6'h02;
            K_JAL:  opcode = 6'h03;
            default: opcode = 6'h3f;
        endcase
    endtask

    // One instruction from FETCH to retirement; abort_mem drops reset
    // after the MEM wait cycles instead of acknowledging.
    task automatic run_instr(input kind_t k, input int fw, input int mw,
                             input logic z, input bit abort_mem);
        exp_t e;
        bit   is_mem;
        is_mem = (k == K_LW || k == K_LB || k == K_SW);
        encode(k);
        for (int i = 0; i < fw; i++) begin
            bus.mem_ack = 1'b0; zero = 1'($urandom);
            e = idle(); e.mem_req = 1'b1;
            step(e, 1'b0);
        end
        bus.mem_ack = 1'b1; zero = 1'($urandom);
        e = idle(); e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        step(e, 1'b0);

        bus.mem_ack = 1'($urandom); zero = 1'($urandom);
        step(idle(), k == K_NOP);
        if (k == K_NOP || k == K_ILL) return;

        bus.mem_ack = 1'($urandom); zero = z;
        e = idle();
        case (k)
            K_SUBU: e.alu_op = 3'd1;
            K_ORI:  begin e.alu_op = 3'd2; e.alu_src = 1'b1; end
            K_LUI:  begin e.alu_src = 1'b1; e.ext_op = 2'd2; end
            K_LW, K_LB, K_SW: begin e.alu_src = 1'b1; e.ext_op = 2'd1; end
            K_BEQ:  begin e.alu_op = 3'd1; e.ext_op = 2'd1; e.npc_sel = 3'd1; e.pc_we = z; end
            K_J:    begin e.pc_we = 1'b1; e.npc_sel = 3'd2; end
            K_JAL:  begin
                e.pc_we = 1'b1; e.npc_sel = 3'd2;
                e.reg_we = 1'b1; e.reg_dst = 2'd2; e.mem2reg = 3'd3;
            end
            K_JR:   begin e.pc_we = 1'b1; e.npc_sel = 3'd3; end
            default: ;
        endcase
        step(e, k == K_BEQ || k == K_J || k == K_JAL || k == K_JR);
        if (k == K_BEQ || k == K_J || k == K_JAL || k == K_JR) return;

        if (is_mem) begin
            e = idle();
            e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (k == K_SW);
            e.alu_src = 1'b1; e.ext_op = 2'd1;
            for (int i = 0; i < mw; i++) begin
                bus.mem_ack = 1'b0; zero = 1'($urandom);
                step(e, 1'b0);
            end
            if (abort_mem) begin
                reset = 1'b0; bus.mem_ack = 1'b1;
                e = idle(); e.rst_low = 1'b1;
                step(e, 1'b0);
                reset = 1'b1;
                return;
            end
            bus.mem_ack = 1'b1;
            step(e, k == K_SW);
            if (k == K_SW) return;
        end

        bus.mem_ack = 1'($urandom); zero = 1'($urandom);
        e = idle(); e.reg_we = 1'b1;
        case (k)
            K_ADDU, K_SUBU: e.reg_dst = 2'd1;
            K_LUI: begin e.ext_op = 2'd2; e.mem2reg = 3'd2; end
            K_LW:  e.mem2reg = 3'd1;
            K_LB:  e.mem2reg = 3'd4;
            default: ;
        endcase
        step(e, 1'b1);
    endtask

    initial begin
        exp_t e;
        int   s0, s1, s2, s3, s4, sh, sr;
        int   req_seen;
        kind_t k;

        bus.mem_ack = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = idle(); e.rst_low = 1'b1;
            step(e, 1'b0);
        end
        reset = 1'b1;

        // directed: addu, lw with 2 wait cycles, sw, beq zero=0 / zero=1
        s0 = hist.size();
        run_instr(K_ADDU, 0, 0, 1'b0, 1'b0);
        s1 = hist.size();
        run_instr(K_LW, 0, 2, 1'b0, 1'b0);
        s2 = hist.size();
        run_instr(K_SW, 0, 0, 1'b0, 1'b0);
        s3 = hist.size();
        run_instr(K_BEQ, 0, 0, 1'b0, 1'b0);
        s4 = hist.size();
        run_instr(K_BEQ, 0, 0, 1'b1, 1'b0);
        run_instr(K_NOP, 0, 0, 1'b0, 1'b0);

        lit("first_req", {31'd0, hist[s0].mem_req}, 32'd1);
        lit("first_iord", {31'd0, hist[s0].iord}, 32'd0);
        lit("first_ir_we", {31'd0, hist[s0].ir_we}, 32'd1);
        lit("decode_no_req", {31'd0, hist[s0+1].mem_req}, 32'd0);
        lit("addu_wb_reg_dst", {30'd0, hist[s0+3].reg_dst}, 32'd1);
        lit("addu_wb_reg_we", {31'd0, hist[s0+3].reg_we}, 32'd1);
        lit("addu_cycles", s1 - s0, 32'd4);
        lit("addu_retired", hist[s1].retired, PERF ? 32'd1 : 32'd0);
        lit("lw_cycles", s2 - s1, 32'd7);
        lit("lw_mem_held", {29'd0, hist[s1+3].iord, hist[s1+4].iord, hist[s1+5].mem_req}, 32'd7);
        lit("lw_wb_mem2reg", {29'd0, hist[s1+6].mem2reg}, 32'd1);
        lit("sw_mem_we", {31'd0, hist[s2+3].mem_we}, 32'd1);
        lit("sw_cycles", s3 - s2, 32'd4);
        lit("beq0_pc_we", {31'd0, hist[s3+2].pc_we}, 32'd0);
        lit("beq1_pc_we", {31'd0, hist[s4+2].pc_we}, 32'd1);
        lit("beq_npc_sel", {26'd0, hist[s3+2].npc_sel, hist[s4+2].npc_sel}, 32'd9);
        lit("beq_cycles", s4 - s3, 32'd3);
        lit("cycle_count_21", hist[s4+3].cycles, PERF ? 32'd21 : 32'd0);
        lit("retired_5", hist[s4+3].retired, PERF ? 32'd5 : 32'd0);

        // randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            k = kind_t'($urandom_range(0, 11));
            run_instr(k,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      1'($urandom), 1'b0);
        end

        // illegal opcode, then reset out of HALT
        run_instr(K_ILL, 0, 0, 1'b0, 1'b0);
        sh = hist.size();
        for (int i = 0; i < 10; i++) begin
            bus.mem_ack = 1'($urandom); zero = 1'($urandom);
            e = idle(); e.halted = 1'b1;
            step(e, 1'b0);
        end
        req_seen = 0;
        for (int i = sh; i < sh + 10; i++) req_seen += int'(hist[i].mem_req);
        lit("halt_no_req", req_seen, 32'd0);
        lit("halted_set", {31'd0, hist[sh+9].halted}, 32'd1);
        reset = 1'b0;
        e = idle(); e.rst_low = 1'b1;
        step(e, 1'b0);
        reset = 1'b1;
        sr = hist.size();
        run_instr(K_ORI, 0, 0, 1'b0, 1'b0);
        lit("halt_cleared", {31'd0, hist[sr].halted}, 32'd0);
        lit("halt_restart_req", {31'd0, hist[sr].mem_req}, 32'd1);
        lit("halt_restart_cycles", hist[sr].cycles, 32'd0);

        // reset during a MEM wait with the ack landing under reset
        run_instr(K_LW, 0, 1, 1'b0, 1'b1);
        lit("abort_req_low", {31'd0, hist[hist.size()-1].mem_req}, 32'd0);
        sr = hist.size();
        run_instr(K_JAL, 1, 0, 1'b0, 1'b0);
        lit("abort_restart_req", {30'd0, hist[sr].mem_req, hist[sr].iord}, 32'd2);
        lit("abort_restart_cycles", hist[sr].cycles, 32'd0);
        lit("abort_restart_retired", hist[sr].retired, 32'd0);

        for (int n = 0; n < 40; n++) begin
            k = kind_t'($urandom_range(0, 11));
            run_instr(k, $urandom_range(0, 1), $urandom_range(0, 1), 1'($urandom), 1'b0);
        end

        @(negedge clk);
        lit("queue_drained", expq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle decoder: it sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, and arbitrates one shared memory port between instruction fetch and data access through a req/ack handshake. It drives every datapath strobe and mux select from the registered IR opcode/funct fields.

## Interface

Parameters:
- None.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; 0 on a rising edge resets the block
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH ack
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag, valid in EXEC
- mem_ack  in  1  shared memory has completed the current request this cycle
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  0 = instruction address (PC), 1 = data address (ALU result)
- ir_we, pc_we, reg_we  out  1 each  IR, PC and GRF write enables
- alu_op  out  3  0 add, 1 sub, 2 or
- alu_src  out  1  0 = RD2, 1 = extended immediate
- ext_op  out  2  0 zero-extend, 1 sign-extend, 2 load-upper
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- mem2reg  out  3  0 ALU, 1 mem word, 2 ext, 3 link (current PC), 4 mem byte
- npc_sel  out  3  0 PC+4, 1 branch, 2 jump26, 3 register (jr)
- halted  out  1  illegal instruction seen
- instr_retired  out  32  retired-instruction count (see Configuration)
- cycle_count  out  32  cycles since reset (see Configuration)

## Operation

- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore decodes of state and opcode/funct. Exceptions: ir_we and pc_we in FETCH = mem_ack, and pc_we in EXEC for beq = zero.
- FETCH: mem_req=1, iord=0, npc_sel=0. On mem_ack: IR and PC written (PC becomes PC+4), then go to DECODE. Otherwise stay.
- DECODE: no strobes.
  - addu (000000/100001), subu (000000/100011), ori (001101), lui (001111), lw (100011), lb (100000), sw (101011), beq (000100) → EXEC.
  - j (000010), jal (000011), jr (000000/001000) → EXEC.
  - nop (000000/000000) → FETCH, counts as retired.
  - Any other encoding → HALT.
- EXEC:
  - addu/subu/ori/lui: ALU controls driven, then → WB.
  - lw/lb/sw: alu_op=0, alu_src=1, ext_op=1, then → MEM.
  - beq: alu_op=1, alu_src=0, ext_op=1, npc_sel=1, pc_we=zero, then → FETCH.
  - j: pc_we=1, npc_sel=2, then → FETCH.
  - jal: j controls plus reg_we=1, reg_dst=2, mem2reg=3, then → FETCH.
  - jr: pc_we=1, npc_sel=3, then → FETCH.
- MEM: mem_req=1, iord=1, mem_we=1 for sw. ALU controls are held.
  - On mem_ack: sw → FETCH; lw/lb → WB. Otherwise stay.
- WB: reg_we=1.
  - addu/subu: reg_dst=1, mem2reg=0.
  - ori: reg_dst=0, ext_op=0, mem2reg=0.
  - lui: reg_dst=0, ext_op=2, mem2reg=2.
  - lw: reg_dst=0, mem2reg=1.
  - lb: reg_dst=0, mem2reg=4.
  - Then → FETCH.
- HALT: halted=1, all strobes 0. Only reset exits HALT.
- Outputs not listed for a state are 0.

## Timing

- Reset (reset=0 at an edge): next state FETCH, counters 0, halted 0.
- While reset=0, all strobes and mem_req are forced 0 combinationally.
- First mem_req is in the first cycle with reset=1.
- Reset in any state, including mid-handshake: the request is abandoned, and a later mem_ack is ignored.
- mem_ack while mem_req=0 is ignored.
- mem_ack in the same cycle as mem_req rise is legal (zero wait).
- Cycles per instruction with zero-wait memory:
  - nop: 2
  - beq, j, jal, jr: 3
  - addu, subu, ori, lui, sw: 4
  - lw, lb: 5
- Each memory wait cycle adds 1.
- mem_req and iord are stable while waiting for ack.

## Configuration

- MC_CTRL_PERF_EN defined:
  - cycle_count increments every cycle with reset=1, wrapping at 2^32.
  - instr_retired increments on each transition into FETCH from DECODE (nop), EXEC, MEM or WB, wrapping.
  - HALT does not count.
- Undefined: both outputs constant 0, with no counter flops.

## Test plan

- Reset held low 3 cycles, released, mem_ack=1 always → mem_req=1 first cycle, iord=0; ir_we=pc_we=1 same cycle; DECODE next.
- addu (funct 100001) zero-wait → 4 cycles. WB cycle: reg_we=1, reg_dst=1, mem2reg=0. instr_retired=1 after (PERF_EN).
- lw with mem_ack delayed 2 cycles in MEM → 7 total cycles. mem_req/iord=1 held steady. WB: mem2reg=1. sw variant: mem_we=1, no WB.
- beq with zero=0 then zero=1 → pc_we 0 then 1 in EXEC; npc_sel=1 both times; 3 cycles each.
- opcode 111111 → HALT, halted=1, no mem_req for 10 cycles. reset=0 one edge → FETCH, halted=0.
- reset=0 during MEM wait, with mem_ack arriving the next cycle → strobes 0, ack ignored; restarts at FETCH with counters 0.
